dcache_mem_responder: RTL and testbench

Memory-side responder for the data-cache refill and write-through channels. It accepts line-refill read requests and single-word strobed write requests from the core data-cache controller, and services them from a byte-enabled backing SRAM. Each completed transfer is signalled with a one-cycle done pulse. It sits at the memory end of the cache's read/write channels and serves as the system memory model for single-core bring-up and the cache verification bench.

---
 rtl/core_mem_pkg.sv | 38 +++
 rtl/dcache_mem_responder_if.sv | 33 +++
 rtl/dcache_backing_ram.sv | 36 +++
 rtl/dcache_mem_responder.sv | 191 +++++++++++++++++++
 tb/tb_dcache_mem_responder.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/core_mem_pkg.sv
// Shared definitions for the data-cache memory responder.
// Contents:
//   - resp_state_e   : responder FSM states
//   - line geometry  : WORDS_PER_LINE, LINE_OFFSET_BITS, WORD_OFFSET_BITS
//   - lane_shift()   : moves an LSB-aligned store into its byte lanes and
//                      returns {byte_enable[7:0], shifted_data[63:0]}
package core_mem_pkg;

    localparam int WORDS_PER_LINE   = 4;
    localparam int LINE_OFFSET_BITS = 5;
    localparam int WORD_OFFSET_BITS = 3;
    localparam int WORD_BYTES       = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT     = 3'd1,
        ST_RD_BEAT  = 3'd2,
        ST_RD_DRAIN = 3'd3,
        ST_RD_DONE  = 3'd4,
        ST_WR_EXEC  = 3'd5,
        ST_WR_DONE  = 3'd6
    } resp_state_e;

    // Bytes shifted past lane 7 fall off the top; the requester promises
    // this never happens for legal stores.
    function automatic logic [71:0] lane_shift(
        input logic [63:0] data,
        input logic [7:0]  strobe,
        input logic [2:0]  byte_off
    );
        logic [7:0]  be;
        logic [63:0] sd;
        be = strobe << byte_off;
        sd = data << {byte_off, 3'b000};
        return {be, sd};
    endfunction

endpackage

// File: rtl/dcache_mem_responder_if.sv
// Request/response bundle between the data-cache controller (master) and
// the memory responder (slave).
//   read channel : i_mem_read_req, i_mem_read_address -> o_mem_read_done, o_mem_read_data
//   write channel: i_mem_write_valid/data/address/strobe -> o_mem_write_done
//   status       : o_busy
interface dcache_mem_responder_if #(
    parameter int ADDR_WIDTH      = 64,
    parameter int CORE_DATA_WIDTH = 64,
    parameter int AXI_DATA_WIDTH  = 256
);
    logic                       i_mem_read_req;
    logic [ADDR_WIDTH-1:0]      i_mem_read_address;
    logic                       o_mem_read_done;
    logic [AXI_DATA_WIDTH-1:0]  o_mem_read_data;
    logic                       i_mem_write_valid;
    logic [CORE_DATA_WIDTH-1:0] i_mem_write_data;
    logic [ADDR_WIDTH-1:0]      i_mem_write_address;
    logic [7:0]                 i_mem_write_strobe;
    logic                       o_mem_write_done;
    logic                       o_busy;

    modport master (
        output i_mem_read_req, i_mem_read_address,
        output i_mem_write_valid, i_mem_write_data, i_mem_write_address, i_mem_write_strobe,
        input  o_mem_read_done, o_mem_read_data, o_mem_write_done, o_busy
    );

    modport slave (
        input  i_mem_read_req, i_mem_read_address,
        input  i_mem_write_valid, i_mem_write_data, i_mem_write_address, i_mem_write_strobe,
        output o_mem_read_done, o_mem_read_data, o_mem_write_done, o_busy
    );
endinterface

// File: rtl/dcache_backing_ram.sv
// Single-port backing SRAM with synchronous (read-first) read and
// byte-enabled write. Contents are never reset.
// Ports: i_clk, i_en (port enable), i_we (write), i_be (byte enables),
//        i_addr (word index), i_wdata, o_rdata (valid the cycle after i_en).
module dcache_backing_ram #(
    parameter int    DEPTH      = 1024,
    parameter int    DATA_WIDTH = 64,
    parameter string INIT_FILE  = ""
) (
    input  logic                      i_clk,
    input  logic                      i_en,
    input  logic                      i_we,
    input  logic [DATA_WIDTH/8-1:0]   i_be,
    input  logic [$clog2(DEPTH)-1:0]  i_addr,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    output logic [DATA_WIDTH-1:0]     o_rdata
);
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Byte-enabled write and registered read on the single port.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                    if (i_be[b]) begin
                        mem_r[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end
            rdata_r <= mem_r[i_addr];
        end
    end

    assign o_rdata = rdata_r;
endmodule

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the data-cache refill and write-through channels.
// Serves 4-word line refills and single-word strobed stores from a backing
// SRAM, each finished with a one-cycle done pulse.
// Ports: i_clk, i_rst (synchronous, active-high), mem_if (slave side of
//        dcache_mem_responder_if: read/write channels, done pulses, o_busy).
module dcache_mem_responder
    import core_mem_pkg::*;
#(
    parameter int    ADDR_WIDTH      = 64,
    parameter int    CORE_DATA_WIDTH = 64,
    parameter int    AXI_DATA_WIDTH  = 256,
    parameter int    MEM_DEPTH_WORDS = 1024,
    parameter int    WAIT_CYCLES     = 2,
    parameter string INIT_FILE       = ""
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    dcache_mem_responder_if.slave mem_if
);
    localparam int IDX_W      = $clog2(MEM_DEPTH_WORDS);
    localparam int LINE_IDX_W = IDX_W - 2;
    localparam int CNT_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    resp_state_e                 state_r, state_next_s;
    logic [CNT_W-1:0]            wait_cnt_r, wait_cnt_next_s;
    logic [1:0]                  beat_r, beat_next_s;
    logic                        accept_wr_s, accept_rd_s;
    logic                        op_wr_r;
    logic [LINE_IDX_W-1:0]       line_idx_r;
    logic [IDX_W-1:0]            wr_idx_r;
    logic [7:0]                  wr_be_r;
    logic [CORE_DATA_WIDTH-1:0]  wr_data_r;
    logic [71:0]                 shifted_s;
    logic                        cap_en_r;
    logic [1:0]                  cap_lane_r;
    logic [WORDS_PER_LINE-1:0][CORE_DATA_WIDTH-1:0] line_buf_r;
    logic                        read_done_r, write_done_r, busy_r;
    logic                        ram_en_s, ram_we_s;
    logic [IDX_W-1:0]            ram_addr_s;
    logic [CORE_DATA_WIDTH-1:0]  ram_rdata_s;
    logic                        unused_s;

    assign shifted_s = lane_shift(mem_if.i_mem_write_data, mem_if.i_mem_write_strobe,
                                  mem_if.i_mem_write_address[2:0]);

    // Next-state, counter and accept decode for the responder FSM.
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        beat_next_s     = beat_r;
        accept_wr_s     = 1'b0;
        accept_rd_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Write has priority; a concurrent read waits until WR_DONE.
                if (mem_if.i_mem_write_valid) begin
                    accept_wr_s = 1'b1;
                    beat_next_s = 2'd0;
                    if (WAIT_CYCLES > 0) begin
                        state_next_s    = ST_WAIT;
                        wait_cnt_next_s = WAIT_LOAD;
                    end else begin
                        state_next_s = ST_WR_EXEC;
                    end
                end else if (mem_if.i_mem_read_req) begin
                    accept_rd_s = 1'b1;
                    beat_next_s = 2'd0;
                    if (WAIT_CYCLES > 0) begin
                        state_next_s    = ST_WAIT;
                        wait_cnt_next_s = WAIT_LOAD;
                    end else begin
                        state_next_s = ST_RD_BEAT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = op_wr_r ? ST_WR_EXEC : ST_RD_BEAT;
                end else begin
                    wait_cnt_next_s = wait_cnt_r - CNT_W'(1);
                end
            end
            ST_RD_BEAT: begin
                beat_next_s = beat_r + 2'd1;
                if (beat_r == 2'd3) begin
                    state_next_s = ST_RD_DRAIN;
                end else begin
                    state_next_s = ST_RD_BEAT;
                end
            end
            ST_RD_DRAIN: state_next_s = ST_RD_DONE;
            ST_RD_DONE:  state_next_s = ST_IDLE;
            ST_WR_EXEC:  state_next_s = ST_WR_DONE;
            ST_WR_DONE:  state_next_s = ST_IDLE;
            default:     state_next_s = ST_IDLE;
        endcase
    end

    // SRAM port steering: writes only in WR_EXEC, beat reads in RD_BEAT.
    assign ram_we_s   = (state_r == ST_WR_EXEC);
    assign ram_en_s   = (state_r == ST_RD_BEAT) || ram_we_s;
    assign ram_addr_s = ram_we_s ? wr_idx_r : {line_idx_r, beat_r};

    // FSM state and counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= {CNT_W{1'b0}};
            beat_r     <= 2'd0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            beat_r     <= beat_next_s;
        end
    end

    // Request latch taken on the accept cycle; the request may drop afterwards.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_wr_r    <= 1'b0;
            line_idx_r <= {LINE_IDX_W{1'b0}};
            wr_idx_r   <= {IDX_W{1'b0}};
            wr_be_r    <= 8'h00;
            wr_data_r  <= {CORE_DATA_WIDTH{1'b0}};
        end else if (accept_wr_s) begin
            op_wr_r   <= 1'b1;
            wr_idx_r  <= mem_if.i_mem_write_address[WORD_OFFSET_BITS+IDX_W-1:WORD_OFFSET_BITS];
            wr_be_r   <= shifted_s[71:64];
            wr_data_r <= shifted_s[63:0];
        end else if (accept_rd_s) begin
            op_wr_r    <= 1'b0;
            line_idx_r <= mem_if.i_mem_read_address[WORD_OFFSET_BITS+IDX_W-1:LINE_OFFSET_BITS];
        end
    end

    // Line capture trails each beat by one cycle to cover SRAM read latency;
    // the DRAIN cycle therefore captures beat 3.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cap_en_r   <= 1'b0;
            cap_lane_r <= 2'd0;
            line_buf_r <= '0;
        end else begin
            cap_en_r   <= (state_r == ST_RD_BEAT);
            cap_lane_r <= beat_r;
            if (cap_en_r) begin
                line_buf_r[cap_lane_r] <= ram_rdata_s;
            end
        end
    end

    // Registered status outputs, decoded from the state being entered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            read_done_r  <= 1'b0;
            write_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            read_done_r  <= (state_next_s == ST_RD_DONE);
            write_done_r <= (state_next_s == ST_WR_DONE);
            busy_r       <= (state_next_s != ST_IDLE);
        end
    end

    dcache_backing_ram #(
        .DEPTH      (MEM_DEPTH_WORDS),
        .DATA_WIDTH (CORE_DATA_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .i_clk   (i_clk),
        .i_en    (ram_en_s),
        .i_we    (ram_we_s),
        .i_be    (wr_be_r),
        .i_addr  (ram_addr_s),
        .i_wdata (wr_data_r),
        .o_rdata (ram_rdata_s)
    );

    assign mem_if.o_mem_read_done  = read_done_r;
    assign mem_if.o_mem_read_data  = line_buf_r;
    assign mem_if.o_mem_write_done = write_done_r;
    assign mem_if.o_busy           = busy_r;

    // Upper address bits alias; line offset of a refill address is zero.
    assign unused_s = ^{mem_if.i_mem_read_address[ADDR_WIDTH-1:WORD_OFFSET_BITS+IDX_W],
                        mem_if.i_mem_read_address[LINE_OFFSET_BITS-1:0],
                        mem_if.i_mem_write_address[ADDR_WIDTH-1:WORD_OFFSET_BITS+IDX_W]};
endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed bench for dcache_mem_responder: one instance with WAIT_CYCLES=2
// (dut_a) and one with WAIT_CYCLES=0 (dut_b), selected by sel_b.
module tb_dcache_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    bit          sel_b = 1'b0;
    logic        rd_req = 1'b0;
    logic [63:0] rd_addr = 64'h0;
    logic        wr_valid = 1'b0;
    logic [63:0] wr_addr = 64'h0;
    logic [63:0] wr_data = 64'h0;
    logic [7:0]  wr_strb = 8'h00;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    dcache_mem_responder_if ifa ();
    dcache_mem_responder_if ifb ();

    assign ifa.i_mem_read_req      = rd_req && !sel_b;
    assign ifa.i_mem_read_address  = rd_addr;
    assign ifa.i_mem_write_valid   = wr_valid && !sel_b;
    assign ifa.i_mem_write_data    = wr_data;
    assign ifa.i_mem_write_address = wr_addr;
    assign ifa.i_mem_write_strobe  = wr_strb;
    assign ifb.i_mem_read_req      = rd_req && sel_b;
    assign ifb.i_mem_read_address  = rd_addr;
    assign ifb.i_mem_write_valid   = wr_valid && sel_b;
    assign ifb.i_mem_write_data    = wr_data;
    assign ifb.i_mem_write_address = wr_addr;
    assign ifb.i_mem_write_strobe  = wr_strb;

    logic         done_r_m, done_w_m, busy_m;
    logic [255:0] rdata_m;
    assign done_r_m = sel_b ? ifb.o_mem_read_done  : ifa.o_mem_read_done;
    assign done_w_m = sel_b ? ifb.o_mem_write_done : ifa.o_mem_write_done;
    assign busy_m   = sel_b ? ifb.o_busy           : ifa.o_busy;
    assign rdata_m  = sel_b ? ifb.o_mem_read_data  : ifa.o_mem_read_data;

    dcache_mem_responder #(.WAIT_CYCLES(2)) dut_a (.i_clk(clk), .i_rst(rst), .mem_if(ifa));
    dcache_mem_responder #(.WAIT_CYCLES(0)) dut_b (.i_clk(clk), .i_rst(rst), .mem_if(ifb));

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept happens on the first negedge of the task; latency counts cycles to done.
    task automatic do_write(input bit b, input logic [63:0] a, input logic [63:0] d,
                            input logic [7:0] s, input int exp_lat, input string tag);
        int lat;
        bit seen;
        @(negedge clk);
        sel_b = b; wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (done_w_m) begin
                seen = 1'b1;
                wr_valid = 1'b0;
            end
        end
        wr_valid = 1'b0;
        check_eq({tag, "_wlat"}, lat, exp_lat);
    endtask

    task automatic do_read(input bit b, input logic [63:0] a, input int exp_lat,
                           input string tag, output logic [255:0] line);
        int lat;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        sel_b = b; rd_req = 1'b1; rd_addr = a;
        lat = 0; busy_cnt = 0; seen = 1'b0; line = '0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy_m) busy_cnt++;
            if (done_r_m) begin
                seen = 1'b1;
                rd_req = 1'b0;
                line = rdata_m;
            end
        end
        rd_req = 1'b0;
        check_eq({tag, "_rlat"}, lat, exp_lat);
        check_eq({tag, "_busy"}, busy_cnt, exp_lat);
    endtask

    initial begin
        logic [255:0] line;
        logic [255:0] exp_line;
        int cyc, wlat, rlat;
        bit saw;

        repeat (3) @(negedge clk);
        check_eq("rst_a_rdone", ifa.o_mem_read_done, 1'b0);
        check_eq("rst_a_wdone", ifa.o_mem_write_done, 1'b0);
        check_eq("rst_a_busy", ifa.o_busy, 1'b0);
        check_eq("rst_a_data", ifa.o_mem_read_data, 256'h0);
        check_eq("rst_b_busy", ifb.o_busy, 1'b0);
        rst = 1'b0;

        // Preload line 0x1000 and refill it (W=2).
        do_write(1'b0, 64'h1000, 64'h100, 8'hFF, 4, "pre0");
        do_write(1'b0, 64'h1008, 64'h101, 8'hFF, 4, "pre1");
        do_write(1'b0, 64'h1010, 64'h102, 8'hFF, 4, "pre2");
        do_write(1'b0, 64'h1018, 64'h103, 8'hFF, 4, "pre3");
        do_read(1'b0, 64'h1000, 8, "rd1", line);
        exp_line = {64'h103, 64'h102, 64'h101, 64'h100};
        check_eq("rd1_line", line, exp_line);
        @(negedge clk);
        check_eq("rd1_idle_busy", busy_m, 1'b0);
        check_eq("rd1_hold", rdata_m, exp_line);

        // Byte store into lane 5.
        do_write(1'b0, 64'h1000, 64'h1122334455667788, 8'hFF, 4, "bfill");
        do_write(1'b0, 64'h1005, 64'hAB, 8'h01, 4, "bst");
        do_read(1'b0, 64'h1000, 8, "rd2", line);
        exp_line = {64'h103, 64'h102, 64'h101, 64'h1122AB4455667788};
        check_eq("rd2_line", line, exp_line);

        // Word store into the upper half.
        do_write(1'b0, 64'h2000, 64'h0123456789ABCDEF, 8'hFF, 4, "wfill");
        do_write(1'b0, 64'h2004, 64'hDEADBEEF, 8'h0F, 4, "wst");
        do_read(1'b0, 64'h2000, 8, "rd3", line);
        check_eq("rd3_lane0", line[63:0], 64'hDEADBEEF89ABCDEF);

        // Simultaneous write and read: write first, read accepted after WR_DONE.
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 64'h1010; wr_data = 64'h5555AAAA5555AAAA; wr_strb = 8'hFF;
        rd_req = 1'b1; rd_addr = 64'h1000;
        cyc = 0; wlat = 0; rlat = 0; line = '0;
        while (rlat == 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done_w_m) begin
                wlat = cyc;
                wr_valid = 1'b0;
            end
            if (done_r_m) begin
                rlat = cyc;
                rd_req = 1'b0;
                line = rdata_m;
            end
        end
        rd_req = 1'b0; wr_valid = 1'b0;
        exp_line = {64'h103, 64'h5555AAAA5555AAAA, 64'h101, 64'h1122AB4455667788};
        check_eq("sim_wdone_cyc", wlat, 4);
        check_eq("sim_rdone_cyc", rlat, 13);
        check_eq("sim_line", line, exp_line);

        // Reset during beat 2 of a refill.
        @(negedge clk);
        rd_req = 1'b1; rd_addr = 64'h1000;
        repeat (5) @(negedge clk);
        check_eq("rstmid_busy_pre", busy_m, 1'b1);
        rst = 1'b1; rd_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rstmid_busy", busy_m, 1'b0);
        check_eq("rstmid_rdone", done_r_m, 1'b0);
        check_eq("rstmid_data", rdata_m, 256'h0);
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done_r_m || busy_m) saw = 1'b1;
        end
        check_eq("rstmid_quiet", saw, 1'b0);
        do_read(1'b0, 64'h1000, 8, "rd4", line);
        check_eq("rd4_line", line, exp_line);

        // W=0 instance: aliasing and minimum latencies.
        do_write(1'b1, 64'h1000, 64'hB0, 8'hFF, 2, "b0");
        do_write(1'b1, 64'h1008, 64'hB1, 8'hFF, 2, "b1");
        do_write(1'b1, 64'h1010, 64'hB2, 8'hFF, 2, "b2");
        do_write(1'b1, 64'h1018, 64'hB3, 8'hFF, 2, "b3");
        do_read(1'b1, 64'h1000 + 64'd1024 * 64'd8, 6, "alias", line);
        check_eq("alias_line", line, {64'hB3, 64'hB2, 64'hB1, 64'hB0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
